// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage and its neighbours: branch-select
// encodings, fetch FSM states and instruction field positions.
package cpu_pkg;

    typedef enum logic [2:0] {
        BR_ALWAYS = 3'b000,
        BR_NEG    = 3'b001,
        BR_ZERO   = 3'b010,
        BR_NZERO  = 3'b011,
        BR_CARRY  = 3'b100,
        BR_NCARRY = 3'b101,
        BR_JR     = 3'b110,
        BR_NONE   = 3'b111
    } br_op_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_LOAD  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } ifu_state_e;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int OFF_MSB = 15;
    localparam int OFF_LSB = 0;
    localparam int OFF_W   = 16;

    localparam logic [5:0] OPC_HALT = 6'd45;

    function automatic logic [5:0] opcode_field(input logic [31:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [OFF_W-1:0] offset_field(input logic [31:0] instr);
        return instr[OFF_MSB:OFF_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_branch_resolve.sv
// Next-PC selection: sequential, PC-relative conditional branch, or jump-register.
// Purely combinational; all arithmetic wraps modulo 2^PC_W.
module branch_resolve
    import cpu_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [2:0]       b_op,
    input  logic             zero_flag,
    input  logic             neg_flag,
    input  logic             carry_flag,
    input  logic [PC_W-1:0]  pc,
    input  logic [OFF_W-1:0] offset,
    input  logic [PC_W-1:0]  rs_value,
    output logic [PC_W-1:0]  next_pc
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    logic [PC_W-1:0] seq_pc_s;
    logic [PC_W-1:0] rel_pc_s;
    logic            taken_s;
    logic            use_rs_s;

    assign seq_pc_s = pc + PC_ONE;
    assign rel_pc_s = seq_pc_s + {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};

    // Branch condition decode; unknown selects fall to sequential
    always_comb begin
        taken_s  = 1'b0;
        use_rs_s = 1'b0;
        case (b_op)
            BR_ALWAYS: taken_s = 1'b1;
            BR_NEG:    taken_s = neg_flag;
            BR_ZERO:   taken_s = zero_flag;
            BR_NZERO:  taken_s = ~zero_flag;
            BR_CARRY:  taken_s = carry_flag;
            BR_NCARRY: taken_s = ~carry_flag;
            BR_JR: begin
                taken_s  = 1'b1;
                use_rs_s = 1'b1;
            end
            BR_NONE:   taken_s = 1'b0;
            default:   taken_s = 1'b0;
        endcase
    end

    // Target mux
    always_comb begin
        next_pc = seq_pc_s;
        if (!taken_s) begin
            next_pc = seq_pc_s;
        end else if (use_rs_s) begin
            next_pc = rs_value;
        end else begin
            next_pc = rel_pc_s;
        end
    end

endmodule

// File: rtl/instr_fetch_unit_chk.sv
// Simulation-only checks for the fetch stage; holds no design state.
module instr_fetch_unit_chk (
    input logic       clk,
    input logic       rst,
    input logic       exec_go,
    input logic [2:0] b_op
);

    // A committing EXEC cycle must see a fully known branch select
    always @(posedge clk) begin
        if (!rst && exec_go) begin
            assert (!$isunknown(b_op));
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter, instruction register and FETCH/LOAD/EXEC/HALT sequencer
// feeding CONTROLLER from a synchronous-read instruction memory.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int               PC_W     = 32,
    parameter int               INSTR_W  = 32,
    parameter logic [PC_W-1:0]  RESET_PC = {PC_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [5:0]         op_code,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    input  logic [2:0]         B_op,
    input  logic               instr_enable,
    input  logic               zero_flag,
    input  logic               neg_flag,
    input  logic               carry_flag,
    input  logic [PC_W-1:0]    rs_value,
    input  logic               ex_stall,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pc_link,
    output logic               halted
);

    ifu_state_e         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               halted_q, halted_d;
    logic [PC_W-1:0]    next_pc_s;
    logic               exec_go_s;

    branch_resolve #(
        .PC_W(PC_W)
    ) u_branch_resolve (
        .b_op       (B_op),
        .zero_flag  (zero_flag),
        .neg_flag   (neg_flag),
        .carry_flag (carry_flag),
        .pc         (pc_q),
        .offset     (offset_field(ir_q[31:0])),
        .rs_value   (rs_value),
        .next_pc    (next_pc_s)
    );

    // X on instr_enable fails the equality and is treated as halt
    assign exec_go_s = (state_q == ST_EXEC) && !ex_stall && (instr_enable == 1'b1);

    // Next-state and register update decode
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        halted_d = halted_q;
        case (state_q)
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                ir_d    = imem_rdata;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (ex_stall) begin
                    state_d = ST_EXEC;
                end else if (instr_enable == 1'b1) begin
                    pc_d    = next_pc_s;
                    state_d = ST_FETCH;
                end else begin
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end
            end
            ST_HALT: begin
                halted_d = 1'b1;
                state_d  = ST_HALT;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // State and architectural registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= {INSTR_W{1'b0}};
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
        end
    end

    // FETCH state is also the reset state, so the read enable is gated by rst
    assign imem_en   = (state_q == ST_FETCH) && !rst;
    assign imem_addr = pc_q;
    assign ir_valid  = (state_q == ST_EXEC);
    assign op_code   = opcode_field(ir_q[31:0]);
    assign ir        = ir_q;
    assign pc        = pc_q;
    assign pc_link   = pc_q + PC_W'(1);
    assign halted    = halted_q;

    instr_fetch_unit_chk u_chk (
        .clk     (clk),
        .rst     (rst),
        .exec_go (exec_go_s),
        .b_op    (B_op)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small synchronous instruction memory.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    logic        clk;
    logic        rst;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [5:0]  op_code;
    logic [31:0] ir;
    logic        ir_valid;
    logic [2:0]  B_op;
    logic        instr_enable;
    logic        zero_flag;
    logic        neg_flag;
    logic        carry_flag;
    logic [31:0] rs_value;
    logic        ex_stall;
    logic [31:0] pc;
    logic [31:0] pc_link;
    logic        halted;

    logic [31:0] mem [0:255];
    int          n_cmp;
    int          n_err;
    logic [31:0] word;

    instr_fetch_unit #(
        .PC_W     (32),
        .INSTR_W  (32),
        .RESET_PC (32'h10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_en      (imem_en),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .op_code      (op_code),
        .ir           (ir),
        .ir_valid     (ir_valid),
        .B_op         (B_op),
        .instr_enable (instr_enable),
        .zero_flag    (zero_flag),
        .neg_flag     (neg_flag),
        .carry_flag   (carry_flag),
        .rs_value     (rs_value),
        .ex_stall     (ex_stall),
        .pc           (pc),
        .pc_link      (pc_link),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr[7:0]];
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_defaults();
        B_op         = 3'b111;
        instr_enable = 1'b1;
        zero_flag    = 1'b0;
        neg_flag     = 1'b0;
        carry_flag   = 1'b0;
        rs_value     = 32'h0;
        ex_stall     = 1'b0;
    endtask

    // Returns at a negedge with ir_valid high, or reports a timeout
    task automatic run_to_exec();
        int cnt;
        cnt = 0;
        while (ir_valid !== 1'b1 && cnt < 8) begin
            @(negedge clk);
            cnt++;
        end
        if (ir_valid !== 1'b1) chk_eq("exec_timeout", 32'(ir_valid), 32'h1);
    endtask

    task automatic exec_instr(input logic [2:0] bop, input logic ie, input logic zf,
                              input logic nf, input logic cf, input logic [31:0] rs);
        run_to_exec();
        B_op = bop; instr_enable = ie; zero_flag = zf; neg_flag = nf;
        carry_flag = cf; rs_value = rs;
        @(negedge clk);
        set_defaults();
    endtask

    task automatic jump_to(input logic [31:0] tgt);
        exec_instr(3'b110, 1'b1, 1'b0, 1'b0, 1'b0, tgt);
    endtask

    // Conditional-branch table at pc 0x30 with offset +5: taken -> 0x36, else 0x31
    logic [2:0] tb_bop [0:7];
    logic [2:0] tb_flg [0:7];
    logic       tb_tkn [0:7];

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) mem[i] = {6'd1, 10'd0, 16'(i)};
        mem[8'h10] = 32'hABCD_0010;
        mem[8'h20] = 32'h0000_FFFE;
        mem[8'h00] = 32'h0000_FFFE;
        mem[8'h30] = 32'h0000_0005;
        mem[8'h08] = 32'h0000_0003;
        mem[8'h05] = {6'd45, 26'd0};
        // {zero,neg,carry}
        tb_bop[0] = 3'b001; tb_flg[0] = 3'b010; tb_tkn[0] = 1'b1;
        tb_bop[1] = 3'b001; tb_flg[1] = 3'b101; tb_tkn[1] = 1'b0;
        tb_bop[2] = 3'b011; tb_flg[2] = 3'b000; tb_tkn[2] = 1'b1;
        tb_bop[3] = 3'b011; tb_flg[3] = 3'b100; tb_tkn[3] = 1'b0;
        tb_bop[4] = 3'b100; tb_flg[4] = 3'b001; tb_tkn[4] = 1'b1;
        tb_bop[5] = 3'b100; tb_flg[5] = 3'b110; tb_tkn[5] = 1'b0;
        tb_bop[6] = 3'b101; tb_flg[6] = 3'b000; tb_tkn[6] = 1'b1;
        tb_bop[7] = 3'b101; tb_flg[7] = 3'b001; tb_tkn[7] = 1'b0;

        set_defaults();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_eq("rst_pc", pc, 32'h10);
        chk_eq("rst_ir", ir, 32'h0);
        chk_eq("rst_halted", 32'(halted), 32'h0);
        chk_eq("rst_imem_en", 32'(imem_en), 32'h0);
        chk_eq("rst_ir_valid", 32'(ir_valid), 32'h0);

        rst = 1'b0;
        #1;
        chk_eq("fetch_en", 32'(imem_en), 32'h1);
        chk_eq("fetch_addr", imem_addr, 32'h10);
        @(negedge clk);
        chk_eq("load_en", 32'(imem_en), 32'h0);
        chk_eq("load_ir_valid", 32'(ir_valid), 32'h0);
        @(negedge clk);
        word = mem[8'h10];
        chk_eq("exec_ir_valid", 32'(ir_valid), 32'h1);
        chk_eq("exec_ir", ir, word);
        chk_eq("exec_opcode", 32'(op_code), 32'(word[31:26]));
        @(negedge clk);
        chk_eq("seq_addr", imem_addr, 32'h11);
        chk_eq("seq_en", 32'(imem_en), 32'h1);

        jump_to(32'h20);
        chk_eq("jr_to_20", pc, 32'h20);
        exec_instr(3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk_eq("bz_taken_neg", pc, 32'h1F);
        jump_to(32'h20);
        exec_instr(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_eq("bz_not_taken", pc, 32'h21);

        jump_to(32'h40);
        run_to_exec();
        chk_eq("pc_link", pc_link, 32'h41);
        exec_instr(3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234);
        chk_eq("jr_target", pc, 32'h1234);

        jump_to(32'hFFFF_FFFF);
        exec_instr(3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_eq("seq_wrap", pc, 32'h0);
        chk_eq("seq_wrap_addr", imem_addr, 32'h0);
        exec_instr(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_eq("neg_off_wrap", pc, 32'hFFFF_FFFF);

        for (int i = 0; i < 8; i++) begin
            jump_to(32'h30);
            exec_instr(tb_bop[i], 1'b1, tb_flg[i][2], tb_flg[i][1], tb_flg[i][0], 32'h0);
            chk_eq($sformatf("cond_%0d", i), pc, tb_tkn[i] ? 32'h36 : 32'h31);
        end

        jump_to(32'h08);
        run_to_exec();
        B_op = 3'b000;
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            zero_flag = ~zero_flag;
            @(negedge clk);
            chk_eq("stall_pc", pc, 32'h08);
            chk_eq("stall_ir", ir, 32'h0000_0003);
            chk_eq("stall_valid", 32'(ir_valid), 32'h1);
        end
        ex_stall = 1'b0;
        @(negedge clk);
        set_defaults();
        chk_eq("stall_release_pc", pc, 32'h0C);

        jump_to(32'h05);
        run_to_exec();
        chk_eq("halt_opcode", 32'(op_code), 32'(OPC_HALT));
        instr_enable = 1'b0;
        @(negedge clk);
        chk_eq("halted_set", 32'(halted), 32'h1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_eq("halt_pc", pc, 32'h05);
            chk_eq("halt_imem_en", 32'(imem_en), 32'h0);
            chk_eq("halt_ir_valid", 32'(ir_valid), 32'h0);
        end
        set_defaults();
        rst = 1'b1;
        #1;
        chk_eq("halt_rst_halted", 32'(halted), 32'h0);
        chk_eq("halt_rst_pc", pc, 32'h10);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_eq("restart_en", 32'(imem_en), 32'h1);
        chk_eq("restart_addr", imem_addr, 32'h10);

        jump_to(32'h50);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_eq("midload_pc", pc, 32'h10);
        chk_eq("midload_ir", ir, 32'h0);
        chk_eq("midload_valid", 32'(ir_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_to_exec();
        chk_eq("resume_pc", pc, 32'h10);
        chk_eq("resume_ir", ir, 32'hABCD_0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
